// File: rtl/replication_pkg.sv
// replication_pkg: frame layout shared by the replication packer and unpacker.
// Frame (7 bits): [6:4] three copies of a, [3:2] b, [1:0] c.
// Stored/decoded entry: {err, a, b[1:0], c[1:0]}.
package replication_pkg;
  localparam int A_REP   = 3;
  localparam int B_W     = 2;
  localparam int C_W     = 2;
  localparam int FRAME_W = 7;

  // field bit positions inside a frame
  localparam int A_HI = 6;
  localparam int A_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 2;
  localparam int C_HI = 1;
  localparam int C_LO = 0;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

  typedef struct packed {
    logic           err;
    logic           a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // 2-of-3 majority
  function automatic logic maj3(input logic [A_REP-1:0] x);
    return (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);
  endfunction
endpackage

// File: rtl/rep_skid_buf.sv
// rep_skid_buf: two-entry skid buffer with registered in_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream (out_data = head entry).
module rep_skid_buf
  import replication_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  buf_state_e   state, state_nxt;
  logic [W-1:0] head, skid;
  logic         in_ready_q;
  logic         acc, xfer;
  logic         ld_head_in, ld_head_skid, ld_skid;

  assign in_ready = in_ready_q;
  assign out_data = head;
  assign acc      = in_valid & in_ready_q;
  assign xfer     = out_valid & out_ready;

  // state register; in_ready follows the next state so it is low exactly in TWO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (acc) state_nxt = ONE;
      ONE: begin
        if (acc && !xfer)      state_nxt = TWO;
        else if (!acc && xfer) state_nxt = EMPTY;
      end
      TWO:     if (xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // outputs and datapath load controls
  always_comb begin
    out_valid    = (state != EMPTY);
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY:   ld_head_in = acc;
      ONE: begin
        // accept+transfer in ONE: new word replaces the departing head
        ld_head_in = acc & xfer;
        ld_skid    = acc & ~xfer;
      end
      TWO:     ld_head_skid = xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (ld_head_in)        head <= in_data;
      else if (ld_head_skid) head <= skid;
      if (ld_skid)           skid <= in_data;
    end
  end
endmodule

// File: rtl/replication_unpack.sv
// replication_unpack: majority-vote decode of {3{a}, b, c} frames, skid-buffered
// output, saturating count of frames whose a copies disagree.
// Ports: clk/rst_n; in_valid/in_ready/in_y upstream; out_valid/out_ready and
//        out_a/out_b/out_c/out_err downstream; clr_cnt clears err_count.
module replication_unpack
  import replication_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAME_W-1:0]   in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_a,
  output logic [B_W-1:0]       out_b,
  output logic [C_W-1:0]       out_c,
  output logic                 out_err,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [A_REP-1:0]   a_cp;
  entry_t             dec, head;
  logic [ENTRY_W-1:0] head_bits;
  logic               acc;

  assign a_cp    = in_y[A_HI:A_LO];
  assign dec.a   = maj3(a_cp);
  assign dec.err = ~((a_cp[2] == a_cp[1]) & (a_cp[1] == a_cp[0]));
  assign dec.b   = in_y[B_HI:B_LO];
  assign dec.c   = in_y[C_HI:C_LO];

  rep_skid_buf #(.W(ENTRY_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_bits)
  );

  assign head    = entry_t'(head_bits);
  assign out_a   = head.a;
  assign out_b   = head.b;
  assign out_c   = head.c;
  assign out_err = head.err;

  assign acc = in_valid & in_ready;

  // clear has priority over a same-cycle error accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (clr_cnt)
      err_count <= '0;
    else if (acc && dec.err && (err_count != CNT_MAX))
      err_count <= err_count + 1'b1;
  end
endmodule

// File: tb/tb_replication_unpack.sv
module tb_replication_unpack;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
  logic [6:0] in_y = '0;

  logic       in_ready, out_valid, out_a, out_err;
  logic [1:0] out_b, out_c;
  logic [7:0] err_count;
  logic       in_ready2, out_valid2, out_a2, out_err2;
  logic [1:0] out_b2, out_c2, err_count2;

  replication_unpack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_err(out_err), .clr_cnt(clr_cnt), .err_count(err_count)
  );

  replication_unpack #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_y(in_y),
    .out_valid(out_valid2), .out_ready(out_ready), .out_a(out_a2), .out_b(out_b2),
    .out_c(out_c2), .out_err(out_err2), .clr_cnt(clr_cnt), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic       a;
    logic [1:0] b;
    logic [1:0] c;
  } exp_t;

  typedef struct {
    logic [6:0] y;
    logic       a;
    logic [1:0] b;
    logic [1:0] c;
    logic       err;
  } vec_t;

  int   n_checks = 0, n_err = 0, n_acc = 0;
  exp_t q[$];
  int   cnt8 = 0, cnt2 = 0;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference decode: count the a copies
  function automatic exp_t model_dec(input logic [6:0] y);
    exp_t e;
    int   ones;
    ones  = int'(y[6]) + int'(y[5]) + int'(y[4]);
    e.a   = (ones >= 2);
    e.err = (ones == 1) || (ones == 2);
    e.b   = y[3:2];
    e.c   = y[1:0];
    return e;
  endfunction

  // drive one cycle from a negedge, advance the model at the posedge, return at next negedge
  task automatic cycle(input logic v, input logic [6:0] y, input logic ordy, input logic clr);
    bit   acc, xf;
    exp_t e;
    in_valid = v; in_y = y; out_ready = ordy; clr_cnt = clr;
    @(posedge clk);
    acc = v && (q.size() < 2);
    xf  = ordy && (q.size() > 0);
    e   = model_dec(y);
    if (xf)  void'(q.pop_front());
    if (acc) begin q.push_back(e); n_acc++; end
    if (clr) begin
      cnt8 = 0; cnt2 = 0;
    end else if (acc && e.err) begin
      if (cnt8 < 255) cnt8++;
      if (cnt2 < 3)   cnt2++;
    end
    @(negedge clk);
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("err_count", 32'(err_count), 32'(cnt8));
    chk("in_ready_w2", 32'(in_ready2), 32'(q.size() < 2));
    chk("out_valid_w2", 32'(out_valid2), 32'(q.size() > 0));
    chk("err_count_w2", 32'(err_count2), 32'(cnt2));
    if (q.size() > 0) begin
      chk("out_word", 32'({out_err, out_a, out_b, out_c}), 32'(q[0]));
      chk("out_word_w2", 32'({out_err2, out_a2, out_b2, out_c2}), 32'(q[0]));
    end
  endtask

  initial begin
    int sat[5];
    int start;
    sat = '{1, 2, 3, 3, 3};
    vt[0] = '{7'b1110111, 1'b1, 2'b01, 2'b11, 1'b0};
    vt[1] = '{7'b0001000, 1'b0, 2'b10, 2'b00, 1'b0};
    vt[2] = '{7'b1010111, 1'b1, 2'b01, 2'b11, 1'b1};
    vt[3] = '{7'b0100100, 1'b0, 2'b01, 2'b00, 1'b1};
    vt[4] = '{7'b0111010, 1'b1, 2'b10, 2'b10, 1'b1};
    vt[5] = '{7'b1101101, 1'b1, 2'b11, 2'b01, 1'b1};
    vt[6] = '{7'b0010001, 1'b0, 2'b00, 2'b01, 1'b1};
    vt[7] = '{7'b1001110, 1'b0, 2'b11, 2'b10, 1'b1};

    // reset state, observed while reset is held
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_out_word", 32'({out_err, out_a, out_b, out_c}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // table vectors, out_ready held high
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vt[i].y, 1'b1, 1'b0);
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_a", 32'(out_a), 32'(vt[i].a));
      chk("vec_b", 32'(out_b), 32'(vt[i].b));
      chk("vec_c", 32'(out_c), 32'(vt[i].c));
      chk("vec_err", 32'(out_err), 32'(vt[i].err));
      if (i == 1) chk("vec_cnt_clean", 32'(err_count), 0);
      if (i == 3) chk("vec_cnt_faults", 32'(err_count), 2);
      check_all();
    end
    cycle(1'b0, 7'd0, 1'b1, 1'b0);
    check_all();

    // backpressure: three frames offered, two taken
    cycle(1'b1, 7'b1110111, 1'b0, 1'b0);
    chk("bp_ready_1", 32'(in_ready), 1);
    check_all();
    cycle(1'b1, 7'b0001000, 1'b0, 1'b0);
    chk("bp_ready_2", 32'(in_ready), 0);
    check_all();
    cycle(1'b1, 7'b1010111, 1'b0, 1'b0);
    chk("bp_ready_3", 32'(in_ready), 0);
    chk("bp_head_hold", 32'({out_a, out_b, out_c}), 32'(5'b1_01_11));
    check_all();
    cycle(1'b1, 7'b1010111, 1'b1, 1'b0);
    chk("bp_ready_back", 32'(in_ready), 1);
    chk("bp_second", 32'({out_err, out_a, out_b, out_c}), 32'(6'b0_0_10_00));
    check_all();
    cycle(1'b1, 7'b1010111, 1'b1, 1'b0);
    chk("bp_third", 32'({out_err, out_a, out_b, out_c}), 32'(6'b1_1_01_11));
    check_all();
    cycle(1'b0, 7'd0, 1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 0);
    check_all();

    // saturation on the 2-bit counter, then clear beating an error accept
    cycle(1'b0, 7'd0, 1'b1, 1'b1);
    chk("sat_clr", 32'(err_count2), 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 7'b1010111, 1'b1, 1'b0);
      chk("sat_cnt", 32'(err_count2), 32'(sat[k]));
      check_all();
    end
    cycle(1'b1, 7'b0100100, 1'b1, 1'b1);
    chk("clr_wins_w2", 32'(err_count2), 0);
    chk("clr_wins", 32'(err_count), 0);
    check_all();
    cycle(1'b0, 7'd0, 1'b1, 1'b0);

    // asynchronous reset with the buffer full
    cycle(1'b1, 7'b0111010, 1'b0, 1'b0);
    cycle(1'b1, 7'b1001110, 1'b0, 1'b0);
    chk("pre_rst_full", 32'(in_ready), 0);
    check_all();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_err_count", 32'(err_count), 0);
    chk("arst_err_count_w2", 32'(err_count2), 0);
    chk("arst_out_word", 32'({out_err, out_a, out_b, out_c}), 0);
    q.delete();
    cnt8 = 0; cnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 7'b1101101, 1'b1, 1'b0);
    chk("post_rst_word", 32'({out_err, out_a, out_b, out_c}), 32'(6'b1_1_11_01));
    check_all();

    // random streaming against the queue model
    start = n_acc;
    for (int c = 0; c < 3000 && n_acc < start + 100; c++) begin
      cycle(logic'($urandom_range(0, 3) != 0), 7'($urandom), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 19) == 0));
      check_all();
    end
    chk("rand_accept_budget", 32'(n_acc >= start + 100), 1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 7'd0, 1'b1, 1'b0);
      check_all();
    end
    chk("rand_drained", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
